// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// The optional watchdog is controlled by MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-state counter for the memory arbiter; flags an access that has gone
// TIMEOUT wait cycles without mem_ack. Only used under MEM_ARB_TIMEOUT_EN.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // An ack in the expiry cycle wins, so expiry is masked by ack.
    assign expired = active & ~ack & (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || start) begin
            count <= '0;
        end else if (active && !ack && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and
// data access; data wins ties. Optional watchdog: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_dm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    arb_state_t state_q, state_d;
    logic       kill_q;
    logic       kill_now;
    logic       wd_expired;

    assign stall_if = if_req & ~if_ready;
    assign stall_dm = dm_req & ~dm_ready;
    assign kill_now = kill_q | if_kill;

`ifdef MEM_ARB_TIMEOUT_EN
    logic wd_start;
    logic wd_active;

    assign wd_start  = (state_q == IDLE) & (dm_req | if_req);
    assign wd_active = (state_q == IF_WAIT) | (state_q == DM_WAIT);

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (wd_start),
        .active  (wd_active),
        .ack     (mem_ack),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    state_d = DM_WAIT;
                end else if (if_req) begin
                    state_d = IF_WAIT;
                end
            end
            IF_WAIT, DM_WAIT: begin
                if (mem_ack || wd_expired) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
            kill_q    <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            bus_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    kill_q <= 1'b0;
                    if (dm_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                end
                IF_WAIT: begin
                    if (if_kill) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_ack || wd_expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= ~mem_ack;
                        // A flushed fetch still completes on the bus but is not delivered.
                        if (!kill_now) begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : DATA_W'(NOP_INSTR);
                        end
                    end
                end
                DM_WAIT: begin
                    if (mem_ack || wd_expired) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        bus_err  <= ~mem_ack;
                        dm_ready <= 1'b1;
                        dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                    end
                end
                RESP: begin
                    kill_q <= 1'b0;
                end
                default: begin
                    kill_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected bus
// requests and read responses; a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, stall_if, dm_ready, stall_dm, mem_req, mem_we, bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .stall_if  (stall_if),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .stall_dm  (stall_dm),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wdata;
    } mem_exp_t;

    mem_exp_t    exp_mem_q[$];
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_dm_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every bus request issue and every ready pulse.
    logic     prev_req = 1'b0;
    mem_exp_t e;
    always @(negedge clk) begin
        if (if_ready) begin
            if (exp_if_q.size() == 0) check("if_ready_unexpected", 1, 0);
            else check("if_rdata", if_rdata, exp_if_q.pop_front());
        end
        if (dm_ready) begin
            if (exp_dm_q.size() == 0) check("dm_ready_unexpected", 1, 0);
            else check("dm_rdata", dm_rdata, exp_dm_q.pop_front());
        end
        if (mem_req && !prev_req) begin
            if (exp_mem_q.size() == 0) begin
                check("mem_req_unexpected", 1, 0);
            end else begin
                e = exp_mem_q.pop_front();
                check("mem_we", mem_we, e.we);
                check("mem_addr", mem_addr, e.addr);
                if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
            end
        end
        prev_req = mem_req;
    end

    // One access starting in the current cycle (cycle 0); ack in cycle k.
    // kill_at: cycle in which if_kill pulses (-1 none, 0 = while IDLE).
    task automatic access(input bit dm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                          input int kill_at, input string tag);
        bit killed;
        killed = !dm && (kill_at >= 1) && (kill_at <= k);
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if_kill = (kill_at == 0);
        exp_mem_q.push_back('{dm ? we : 1'b0, addr, wdata, dm && we});
        @(negedge clk);
        check($sformatf("%s_stall_c0", tag), dm ? stall_dm : stall_if, 1);
        for (int c = 1; c <= k; c++) begin
            tick;
            if_kill = (c == kill_at);
            if (dm) begin
                dm_addr = ~addr; dm_wdata = ~wdata;
            end else begin
                if_addr = ~addr;
            end
            if (c == k) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
                if (dm) exp_dm_q.push_back(we ? 32'h0 : rdata);
                else if (!killed) exp_if_q.push_back(rdata);
            end
            @(negedge clk);
            check($sformatf("%s_stall_c%0d", tag, c), dm ? stall_dm : stall_if, 1);
            check($sformatf("%s_mem_req_c%0d", tag, c), mem_req, 1);
            check($sformatf("%s_mem_addr_c%0d", tag, c), mem_addr, addr);
        end
        tick;
        mem_ack = 1'b0;
        if_kill = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check($sformatf("%s_ready", tag), dm ? dm_ready : if_ready, !killed);
        check($sformatf("%s_mem_req_done", tag), mem_req, 0);
        tick;
        if (dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        if_req = 0; if_kill = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        tick; tick;
        mem_ack = 1'b1;          // stray ack during reset must be ignored
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_bus_err", bus_err, 0);
        tick;
        reset = 1'b0;
        mem_ack = 1'b1;          // ack while IDLE is ignored
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_ignored", {mem_req, if_ready, dm_ready}, 0);
        tick;

        access(0, 0, 32'h100, 32'h0, 1, 32'h0050_0093, -1, "fetch1");

        // Simultaneous requests: store wins, fetch follows.
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
        exp_mem_q.push_back('{1'b1, 32'h2000, 32'hDEAD_BEEF, 1'b1});
        exp_mem_q.push_back('{1'b0, 32'h104, 32'h0, 1'b0});
        @(negedge clk);
        check("sim_stall_if_c0", stall_if, 1);
        check("sim_stall_dm_c0", stall_dm, 1);
        tick;
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        exp_dm_q.push_back(32'h0);
        @(negedge clk);
        check("sim_first_we", mem_we, 1);
        tick;
        mem_ack = 0;
        @(negedge clk);
        check("sim_dm_ready", dm_ready, 1);
        check("sim_if_ready", if_ready, 0);
        check("sim_stall_if_c2", stall_if, 1);
        tick;
        dm_req = 0;
        @(negedge clk);
        check("sim_idle_c3", mem_req, 0);
        tick;
        mem_ack = 1; mem_rdata = 32'h00A0_0113;
        exp_if_q.push_back(32'h00A0_0113);
        @(negedge clk);
        check("sim_fetch_req", mem_req, 1);
        check("sim_fetch_addr", mem_addr, 32'h104);
        tick;
        mem_ack = 0;
        @(negedge clk);
        check("sim_fetch_ready", if_ready, 1);
        tick;
        if_req = 0;

        access(0, 0, 32'h108, 32'h0, 4, 32'hAAAA_5555, 2, "kill");
        access(0, 0, 32'h200, 32'h0, 1, 32'h1111_2222, -1, "after_kill");
        access(0, 0, 32'h10C, 32'h0, 2, 32'h3333_4444, 2, "kill_on_ack");
        access(0, 0, 32'h110, 32'h0, 2, 32'h7777_8888, 0, "kill_in_idle");
        access(1, 0, 32'h3000, 32'h0, 5, 32'h1234_5678, -1, "load5");
        access(1, 1, 32'h2004, 32'hCAFE_F00D, 3, 32'hFFFF_FFFF, -1, "store");

        // Reset in cycle 2 of a data access.
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000;
        exp_mem_q.push_back('{1'b0, 32'h4000, 32'h0, 1'b0});
        tick;
        tick;
        reset = 1;
        @(negedge clk);
        check("rstmid_req_c2", mem_req, 1);
        tick;
        reset = 0; dm_req = 0;
        @(negedge clk);
        check("rstmid_req_c3", mem_req, 0);
        tick;
        mem_ack = 1; mem_rdata = 32'h9999_9999;
        @(negedge clk);
        check("rstmid_req_c4", mem_req, 0);
        tick;
        mem_ack = 0;
        @(negedge clk);
        check("rstmid_no_ready", {dm_ready, if_ready}, 0);
        tick;
        access(0, 0, 32'h300, 32'h0, 2, 32'h0000_0513, -1, "after_rst");

`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int c;
            if_req = 1; if_addr = 32'h400;
            exp_mem_q.push_back('{1'b0, 32'h400, 32'h0, 1'b0});
            exp_if_q.push_back(32'h0000_0013);
            for (c = 1; c <= 40; c++) begin
                tick;
                @(negedge clk);
                if (bus_err) break;
            end
            check("to_bus_err_cycle", c, 16);
            check("to_if_ready", if_ready, 1);
            check("to_mem_req", mem_req, 0);
            tick;
            if_req = 0;
            @(negedge clk);
            check("to_bus_err_pulse", bus_err, 0);
        end
`else
        check("no_to_bus_err", bus_err, 0);
`endif

        tick; tick;
        check("exp_mem_drained", exp_mem_q.size(), 0);
        check("exp_if_drained", exp_if_q.size(), 0);
        check("exp_dm_drained", exp_dm_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (instruction read) and the memory-access stage (data load/store) of the 5-stage pipeline.
- Sequences each access as a request/acknowledge transaction with variable memory latency.
- Returns the read data to the winning stage.
- Raises per-stage stall requests that the hazard logic ORs into Stall_F, Stall_D and the downstream stage enables.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
TIMEOUT, 15, watchdog cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address (PCF)
if_kill  in  1  fetch flushed (branch/jump taken); discard the outstanding fetch response
if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1
if_ready  out  1  one-cycle fetch completion pulse
stall_if  out  1  = if_req & ~if_ready
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address (ALUResultM)
dm_wdata  in  DATA_W  store data (WriteDataM)
dm_rdata  out  DATA_W  load data (ReadDataM); valid while dm_ready=1
dm_ready  out  1  one-cycle data completion pulse
stall_dm  out  1  = dm_req & ~dm_ready
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle memory completion
bus_err  out  1  one-cycle timeout pulse; constant 0 without MEM_ARB_TIMEOUT_EN

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: all registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata, bus_err. The state register is IDLE.
- FSM states: IDLE, IF_WAIT, DM_WAIT, RESP.
- IDLE:
  - dm_req=1 → DM_WAIT. Data wins over fetch because it belongs to the older instruction. mem_req=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata are latched at the same edge.
  - else if_req=1 → IF_WAIT. mem_req=1, mem_we=0, mem_addr=if_addr are latched.
  - else remain in IDLE.
- IF_WAIT / DM_WAIT:
  - mem_* outputs hold stable until mem_ack.
  - On mem_ack: mem_req←0 and mem_we←0. The owner's rdata register captures mem_rdata; for a store, dm_rdata←0. The FSM goes to RESP and the owner's ready bit is set for exactly one cycle.
- RESP: one cycle, then → IDLE. Requesters update or deassert req at the edge that ends the ready cycle. IDLE therefore never re-samples a completed request.
- Latency: request seen in cycle 0 → mem_req high from cycle 1. mem_ack in cycle k ≥ 1 → ready in cycle k+1. Minimum is 3 cycles per access.
- if_kill:
  - Sampled in IF_WAIT or on the mem_ack edge; sets a kill flag.
  - The memory transaction still completes, but the RESP cycle asserts no if_ready. if_rdata is unchanged.
  - The flag is cleared on entry to IDLE.
  - if_kill in IDLE or RESP has no effect.
- Ignored inputs:
  - mem_ack in IDLE or RESP is ignored; this covers late acks after reset.
  - Changes to req, addr or wdata during WAIT are ignored because values were latched at grant.
- Reset mid-transaction: the FSM returns to IDLE at the next edge and mem_req drops. No ready pulse is produced for the aborted access.
- Both req asserted for multiple accesses: data is served first. Fetch is served on the next IDLE cycle unless a new dm_req is present. Starvation is bounded because the pipeline stalls while stall_dm=1.

Optional Feature:
Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT-limited counter clears on entry to a WAIT state and increments each WAIT cycle without mem_ack.
  - On reaching TIMEOUT: mem_req←0, bus_err pulses for 1 cycle, FSM → RESP.
  - The ready pulse carries if_rdata=32'h00000013 (NOP) for a fetch, or dm_rdata=0 for data.
  - mem_ack in the same cycle as expiry takes precedence: normal completion, no bus_err.
- Undefined: no counter; WAIT lasts indefinitely; bus_err tied 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the FSM state encoding (2-bit: IDLE=0, IF_WAIT=1, DM_WAIT=2, RESP=3)
  - constant NOP_INSTR=32'h00000013
  - default widths
- Sub-module mem_arb_watchdog contains the timeout counter. It is instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Fetch, ack after 1 cycle: if_req=1, if_addr=0x100; mem_rdata=0x00500093 with mem_ack in cycle 1 → mem_addr=0x100 in cycle 1; if_ready=1 and if_rdata=0x00500093 in cycle 2; stall_if=1 in cycles 0–1.
- Simultaneous requests: if_req (0x104) and dm_req store (0x2000, 0xDEADBEEF) in the same cycle → the first memory transaction is we=1, addr=0x2000, wdata=0xDEADBEEF. dm_ready pulses, then the fetch of 0x104 issues.
- Kill during fetch: if_req to 0x108, if_kill=1 in cycle 2, mem_ack in cycle 4 → no if_ready pulse; FSM back in IDLE in cycle 6; the next request proceeds normally.
- Reset mid-access: reset in cycle 2 of a DM_WAIT → mem_req=0 from cycle 3; mem_ack in cycle 4 is ignored; no dm_ready pulse.
- Load latency 5: dm_req load at 0x3000, mem_ack in cycle 5 with 0x12345678 → dm_ready=1 in cycle 6 with dm_rdata=0x12345678; stall_dm=1 in cycles 0–5.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=15, fetch with no ack → bus_err and if_ready both pulse, if_rdata=0x00000013.
